l2_port_arbiter: RTL and testbench

- Shares the single unified L2 port between the L1 instruction cache (read-only) and the L1 data cache (read/write).
- Arbitrates round-robin and latches the winning request.
- Drives the L2 request and holds it stable until L2 ready, then steers the response to the winner.
- Sits between the two L1 controllers and the L2; request/ready/stall semantics match the existing L1-to-L2 handshake on both sides.

---
 rtl/l2_port_arbiter_if.sv | 52 +++++
 rtl/l2_port_arbiter.sv | 123 ++++++++++++
 tb/tb_l2_port_arbiter.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : l2_port_arbiter_if
// Brief    : I-side, D-side and L2 handshake bundle around the L2 port arbiter
// Revision : 1.0
// ============================================================================
interface l2_port_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int LINE_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_ready;
  logic              i_stall;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_ready;
  logic              d_stall;

  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_ready;

  // Arbiter view: requests from both L1s and L2 responses come in
  modport slave (
    input  i_read, i_addr,
    input  d_read, d_write, d_addr, d_wdata,
    input  l2_rdata, l2_ready,
    output i_rdata, i_ready, i_stall,
    output d_rdata, d_ready, d_stall,
    output l2_read, l2_write, l2_addr, l2_wdata
  );

  // Environment view: the L1 controllers and the L2 together
  modport master (
    output i_read, i_addr,
    output d_read, d_write, d_addr, d_wdata,
    output l2_rdata, l2_ready,
    input  i_rdata, i_ready, i_stall,
    input  d_rdata, d_ready, d_stall,
    input  l2_read, l2_write, l2_addr, l2_wdata
  );
endinterface
`default_nettype wire

// File: rtl/l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_port_arbiter
// Brief    : Round-robin arbiter sharing the unified L2 port between L1 I and D
// Revision : 1.0
// ============================================================================
module l2_port_arbiter #(
  parameter int ADDR_W = 30,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  l2_port_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_GRANT_I = 2'd1;
  localparam logic [1:0] c_GRANT_D = 2'd2;
  localparam logic [1:0] c_RELEASE = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_last_d;
  logic              r_op_read;
  logic              r_op_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_conflict_cnt;

  logic w_i_req;
  logic w_d_req;
  logic w_idle;
  logic w_in_grant;
  logic w_grant_i;
  logic w_grant_d;
  logic w_i_done;
  logic w_d_done;
  logic w_cnt_sat;

  assign w_i_req    = bus.i_read;
  assign w_d_req    = bus.d_read | bus.d_write;
  assign w_idle     = (r_state == c_IDLE);
  assign w_in_grant = (r_state == c_GRANT_I) | (r_state == c_GRANT_D);

  // On a tie the side that did not win last time takes the port
  assign w_grant_i  = w_idle & w_i_req & (~w_d_req | r_last_d);
  assign w_grant_d  = w_idle & w_d_req & (~w_i_req | ~r_last_d);

  assign w_i_done   = (r_state == c_GRANT_I) & bus.l2_ready;
  assign w_d_done   = (r_state == c_GRANT_D) & bus.l2_ready;
  assign w_cnt_sat  = &r_conflict_cnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_grant_i) begin
          w_state_nxt = c_GRANT_I;
        end else if (w_grant_d) begin
          w_state_nxt = c_GRANT_D;
        end
      end
      c_GRANT_I, c_GRANT_D: begin
        if (bus.l2_ready) begin
          w_state_nxt = c_RELEASE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= c_IDLE;
      r_last_d       <= 1'b1;
      r_op_read      <= 1'b0;
      r_op_write     <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_i) begin
        r_last_d   <= 1'b0;
        r_addr     <= bus.i_addr;
        r_wdata    <= '0;
        r_op_read  <= 1'b1;
        r_op_write <= 1'b0;
      end else if (w_grant_d) begin
        // A simultaneous read+write from D is resolved as a write
        r_last_d   <= 1'b1;
        r_addr     <= bus.d_addr;
        r_wdata    <= bus.d_wdata;
        r_op_read  <= bus.d_read & ~bus.d_write;
        r_op_write <= bus.d_write;
      end
      if (w_idle & w_i_req & w_d_req & ~w_cnt_sat) begin
        r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
      end
    end
  end

  // Masking with l2_ready keeps L2 from seeing a fresh request in its ready cycle
  assign bus.l2_read  = w_in_grant & r_op_read  & ~bus.l2_ready;
  assign bus.l2_write = w_in_grant & r_op_write & ~bus.l2_ready;
  assign bus.l2_addr  = r_addr;
  assign bus.l2_wdata = r_wdata;

  assign bus.i_ready  = w_i_done;
  assign bus.d_ready  = w_d_done;
  assign bus.i_rdata  = w_i_done ? bus.l2_rdata : '0;
  assign bus.d_rdata  = w_d_done ? bus.l2_rdata : '0;

  // Stall is gated by reset so it collapses as soon as reset asserts
  assign bus.i_stall  = reset & w_i_req & ~w_i_done;
  assign bus.d_stall  = reset & w_d_req & ~w_d_done;

  assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_port_arbiter
// Brief    : Scoreboard bench for l2_port_arbiter; the bench plays both L1s and L2
// Revision : 1.0
// ============================================================================
module tb_l2_port_arbiter;

  typedef struct {
    logic         side_d;
    logic         wr;
    logic [29:0]  addr;
    logic [127:0] wdata;
  } req_t;

  logic        clk;
  logic        reset;
  logic [15:0] conflict_cnt;
  logic [3:0]  s_conflict_cnt;
  int          checks;
  int          errors;
  req_t        sb_q[$];

  l2_port_arbiter_if #(.ADDR_W(30), .LINE_W(128)) bus ();
  l2_port_arbiter_if #(.ADDR_W(30), .LINE_W(128)) sbus ();

  l2_port_arbiter #(.ADDR_W(30), .LINE_W(128), .CNT_W(16)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  // Narrow counter instance so saturation is reachable in a short run
  l2_port_arbiter #(.ADDR_W(30), .LINE_W(128), .CNT_W(4)) u_dut_sat (
    .clk          (clk),
    .reset        (reset),
    .bus          (sbus),
    .conflict_cnt (s_conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert (!(reset && bus.d_read && bus.d_write)) else $error("illegal d_read and d_write together");
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic req_t mk(input logic side_d, input logic wr, input logic [29:0] addr,
                              input logic [127:0] wdata);
    req_t r;
    r.side_d = side_d;
    r.wr     = wr;
    r.addr   = addr;
    r.wdata  = wdata;
    return r;
  endfunction

  task automatic clear_inputs();
    bus.i_read   = 1'b0;
    bus.i_addr   = '0;
    bus.d_read   = 1'b0;
    bus.d_write  = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.l2_rdata = '0;
    bus.l2_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_req(output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (bus.l2_read || bus.l2_write) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    bus.i_read   = 1'b1;
    bus.d_write  = 1'b1;
    bus.l2_ready = 1'b1;
    bus.l2_rdata = '1;
    #3;
    checks++;
    if ({bus.i_ready, bus.i_stall, bus.d_ready, bus.d_stall, bus.l2_read, bus.l2_write} !== 6'b0 ||
        bus.i_rdata !== '0 || bus.d_rdata !== '0 || bus.l2_addr !== '0 || bus.l2_wdata !== '0)
    begin
      errors++;
      $display("FAIL reset_outputs: got rdy/stall/l2 %b%b%b%b%b%b addr %h, want all 0",
               bus.i_ready, bus.i_stall, bus.d_ready, bus.d_stall, bus.l2_read, bus.l2_write, bus.l2_addr);
    end
    checks++;
    if (conflict_cnt !== 16'h0 || s_conflict_cnt !== 4'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %h/%h want 0/0", conflict_cnt, s_conflict_cnt);
    end
    @(negedge clk);
    checks++;
    if (bus.l2_read !== 1'b0 || bus.l2_write !== 1'b0 || bus.i_ready !== 1'b0 || conflict_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_held: got l2r %b l2w %b irdy %b cnt %h want 0", bus.l2_read, bus.l2_write,
               bus.i_ready, conflict_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_i_read();
    req_t exp;
    int   cyc;
    bit   seen;
    do_reset();
    @(negedge clk);
    bus.i_read = 1'b1;
    bus.i_addr = 30'h40;
    sb_q.push_back(mk(1'b0, 1'b0, 30'h40, 128'h0));
    #1;
    checks++;
    if (bus.i_stall !== 1'b1 || bus.l2_read !== 1'b0) begin
      errors++;
      $display("FAIL t1_wait: got i_stall %b l2_read %b want 1 0", bus.i_stall, bus.l2_read);
    end
    wait_req(cyc, seen);
    checks++;
    if (!seen || cyc != 1) begin
      errors++;
      $display("FAIL t1_latency: got seen %0d after %0d cycles want 1 cycle", seen, cyc);
    end
    exp = sb_q.pop_front();
    checks++;
    if (bus.l2_read !== !exp.wr || bus.l2_write !== exp.wr || bus.l2_addr !== exp.addr) begin
      errors++;
      $display("FAIL t1_req: got r%b w%b addr %h want r%b w%b addr %h", bus.l2_read, bus.l2_write,
               bus.l2_addr, !exp.wr, exp.wr, exp.addr);
    end
    bus.l2_rdata = {16{8'hA5}};
    bus.l2_ready = 1'b1;
    #1;
    checks++;
    if (bus.i_ready !== 1'b1 || bus.i_rdata !== {16{8'hA5}} || bus.l2_read !== 1'b0 ||
        bus.d_ready !== 1'b0 || bus.d_rdata !== '0 || bus.i_stall !== 1'b0) begin
      errors++;
      $display("FAIL t1_ready: got irdy %b irdata %h l2r %b drdy %b istall %b want 1 a5.. 0 0 0",
               bus.i_ready, bus.i_rdata, bus.l2_read, bus.d_ready, bus.i_stall);
    end
    @(negedge clk);
    bus.l2_ready = 1'b0;
    #1;
    checks++;
    if (bus.l2_read !== 1'b0 || bus.i_ready !== 1'b0 || bus.i_stall !== 1'b1) begin
      errors++;
      $display("FAIL t1_release: got l2r %b irdy %b istall %b want 0 0 1", bus.l2_read, bus.i_ready,
               bus.i_stall);
    end
    bus.i_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    req_t exp;
    int   cyc;
    bit   seen;
    do_reset();
    @(negedge clk);
    bus.i_read  = 1'b1;
    bus.i_addr  = 30'h80;
    bus.d_write = 1'b1;
    bus.d_addr  = 30'h100;
    bus.d_wdata = 128'h1234;
    sb_q.push_back(mk(1'b0, 1'b0, 30'h80, 128'h0));
    sb_q.push_back(mk(1'b1, 1'b1, 30'h100, 128'h1234));
    #1;
    checks++;
    if (bus.i_stall !== 1'b1 || bus.d_stall !== 1'b1 || conflict_cnt !== 16'h0) begin
      errors++;
      $display("FAIL t2_wait: got istall %b dstall %b cnt %h want 1 1 0", bus.i_stall, bus.d_stall,
               conflict_cnt);
    end
    wait_req(cyc, seen);
    exp = sb_q.pop_front();
    checks++;
    if (!seen || cyc != 1 || bus.l2_read !== !exp.wr || bus.l2_write !== exp.wr ||
        bus.l2_addr !== exp.addr || conflict_cnt !== 16'h1 || bus.d_stall !== 1'b1) begin
      errors++;
      $display("FAIL t2_first: got cyc %0d r%b w%b addr %h cnt %h dstall %b want 1 r1 w0 addr %h cnt 1 dstall 1",
               cyc, bus.l2_read, bus.l2_write, bus.l2_addr, conflict_cnt, bus.d_stall, exp.addr);
    end
    bus.l2_rdata = 128'hBEEF;
    bus.l2_ready = 1'b1;
    #1;
    checks++;
    if ((exp.side_d ? bus.d_ready : bus.i_ready) !== 1'b1 || (exp.side_d ? bus.i_ready : bus.d_ready) !== 1'b0 ||
        bus.i_rdata !== 128'hBEEF || bus.d_stall !== 1'b1) begin
      errors++;
      $display("FAIL t2_first_ready: got irdy %b drdy %b irdata %h dstall %b want 1 0 beef 1",
               bus.i_ready, bus.d_ready, bus.i_rdata, bus.d_stall);
    end
    @(negedge clk);
    bus.l2_ready = 1'b0;
    bus.i_read   = 1'b0;
    #1;
    checks++;
    if (bus.l2_read !== 1'b0 || bus.l2_write !== 1'b0 || bus.d_stall !== 1'b1) begin
      errors++;
      $display("FAIL t2_release: got l2r %b l2w %b dstall %b want 0 0 1", bus.l2_read, bus.l2_write,
               bus.d_stall);
    end
    wait_req(cyc, seen);
    exp = sb_q.pop_front();
    checks++;
    if (!seen || cyc != 2 || bus.l2_write !== exp.wr || bus.l2_read !== !exp.wr ||
        bus.l2_addr !== exp.addr || bus.l2_wdata !== exp.wdata || conflict_cnt !== 16'h1) begin
      errors++;
      $display("FAIL t2_second: got cyc %0d r%b w%b addr %h wdata %h cnt %h want 2 r0 w1 addr %h wdata %h cnt 1",
               cyc, bus.l2_read, bus.l2_write, bus.l2_addr, bus.l2_wdata, conflict_cnt, exp.addr, exp.wdata);
    end
    bus.l2_rdata = 128'h77;
    bus.l2_ready = 1'b1;
    #1;
    checks++;
    if ((exp.side_d ? bus.d_ready : bus.i_ready) !== 1'b1 || bus.d_stall !== 1'b0 ||
        bus.d_rdata !== 128'h77 || bus.i_ready !== 1'b0 || bus.i_rdata !== '0 || bus.l2_write !== 1'b0) begin
      errors++;
      $display("FAIL t2_second_ready: got drdy %b dstall %b drdata %h irdy %b l2w %b want 1 0 77 0 0",
               bus.d_ready, bus.d_stall, bus.d_rdata, bus.i_ready, bus.l2_write);
    end
    @(negedge clk);
    bus.l2_ready = 1'b0;
    bus.d_write  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    req_t         exp;
    int           cyc;
    bit           seen;
    int           ni;
    int           nd;
    int           idx;
    logic [127:0] rd;
    do_reset();
    ni = 0;
    nd = 0;
    for (int k = 0; k < 7; k++) begin
      idx = k / 2;
      if (k % 2 == 0) sb_q.push_back(mk(1'b0, 1'b0, 30'h1000 + 30'(idx * 4), 128'h0));
      else            sb_q.push_back(mk(1'b1, (idx % 2) == 0, 30'h2000 + 30'(idx * 4), 128'hD0 + 128'(idx)));
    end
    @(negedge clk);
    bus.i_read  = 1'b1;
    bus.i_addr  = 30'h1000;
    bus.d_write = 1'b1;
    bus.d_read  = 1'b0;
    bus.d_addr  = 30'h2000;
    bus.d_wdata = 128'hD0;
    for (int k = 0; k < 7; k++) begin
      wait_req(cyc, seen);
      exp = sb_q.pop_front();
      checks++;
      if (!seen || cyc != ((k == 0) ? 1 : 2) || bus.l2_read !== !exp.wr || bus.l2_write !== exp.wr ||
          bus.l2_addr !== exp.addr || (exp.wr && bus.l2_wdata !== exp.wdata)) begin
        errors++;
        $display("FAIL t3_req%0d: got cyc %0d r%b w%b addr %h wdata %h want cyc %0d r%b w%b addr %h wdata %h",
                 k, cyc, bus.l2_read, bus.l2_write, bus.l2_addr, bus.l2_wdata, (k == 0) ? 1 : 2,
                 !exp.wr, exp.wr, exp.addr, exp.wdata);
      end
      rd = {4{32'hC0DE_0000 + 32'(k)}};
      bus.l2_rdata = rd;
      bus.l2_ready = 1'b1;
      #1;
      checks++;
      if (exp.side_d ? (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b0 || bus.d_rdata !== rd)
                     : (bus.i_ready !== 1'b1 || bus.d_ready !== 1'b0 || bus.i_rdata !== rd)) begin
        errors++;
        $display("FAIL t3_grant%0d: got irdy %b drdy %b irdata %h drdata %h want side_d %b rdata %h",
                 k, bus.i_ready, bus.d_ready, bus.i_rdata, bus.d_rdata, exp.side_d, rd);
      end
      @(negedge clk);
      bus.l2_ready = 1'b0;
      #1;
      checks++;
      if (bus.l2_read !== 1'b0 || bus.l2_write !== 1'b0) begin
        errors++;
        $display("FAIL t3_release%0d: got l2r %b l2w %b want 0 0", k, bus.l2_read, bus.l2_write);
      end
      if (exp.side_d) begin
        nd++;
        if (nd < 3) begin
          bus.d_addr  = 30'h2000 + 30'(nd * 4);
          bus.d_write = (nd % 2) == 0;
          bus.d_read  = (nd % 2) != 0;
          bus.d_wdata = 128'hD0 + 128'(nd);
        end else begin
          bus.d_write = 1'b0;
          bus.d_read  = 1'b0;
        end
      end else begin
        ni++;
        if (ni < 4) bus.i_addr = 30'h1000 + 30'(ni * 4);
        else        bus.i_read = 1'b0;
      end
    end
    checks++;
    if (conflict_cnt !== 16'd6) begin
      errors++;
      $display("FAIL t3_conflicts: got %0d want 6", conflict_cnt);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_addr_hold();
    req_t exp;
    int   cyc;
    bit   seen;
    do_reset();
    @(negedge clk);
    bus.d_read = 1'b1;
    bus.d_addr = 30'h100;
    sb_q.push_back(mk(1'b1, 1'b0, 30'h100, 128'h0));
    wait_req(cyc, seen);
    exp = sb_q.pop_front();
    checks++;
    if (!seen || bus.l2_read !== 1'b1 || bus.l2_addr !== exp.addr) begin
      errors++;
      $display("FAIL t4_req: got l2r %b addr %h want 1 %h", bus.l2_read, bus.l2_addr, exp.addr);
    end
    bus.d_addr  = 30'h200;
    bus.d_wdata = 128'hFACE;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.l2_addr !== exp.addr || bus.l2_read !== 1'b1 || bus.l2_write !== 1'b0 || bus.d_stall !== 1'b1) begin
        errors++;
        $display("FAIL t4_hold: got addr %h l2r %b l2w %b dstall %b want %h 1 0 1", bus.l2_addr,
                 bus.l2_read, bus.l2_write, bus.d_stall, exp.addr);
      end
    end
    bus.l2_rdata = 128'h5A;
    bus.l2_ready = 1'b1;
    #1;
    checks++;
    if (bus.d_ready !== 1'b1 || bus.d_rdata !== 128'h5A || bus.l2_addr !== exp.addr || bus.l2_read !== 1'b0) begin
      errors++;
      $display("FAIL t4_ready: got drdy %b drdata %h addr %h l2r %b want 1 5a %h 0", bus.d_ready,
               bus.d_rdata, bus.l2_addr, bus.l2_read, exp.addr);
    end
    @(negedge clk);
    bus.l2_ready = 1'b0;
    bus.d_read   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    req_t exp;
    int   cyc;
    bit   seen;
    do_reset();
    @(negedge clk);
    bus.i_read  = 1'b1;
    bus.i_addr  = 30'h40;
    bus.d_write = 1'b1;
    bus.d_addr  = 30'h300;
    bus.d_wdata = 128'h55;
    sb_q.push_back(mk(1'b0, 1'b0, 30'h40, 128'h0));
    sb_q.push_back(mk(1'b1, 1'b1, 30'h300, 128'h55));
    wait_req(cyc, seen);
    exp = sb_q.pop_front();
    bus.l2_ready = 1'b1;
    @(negedge clk);
    bus.l2_ready = 1'b0;
    bus.i_read   = 1'b0;
    wait_req(cyc, seen);
    exp = sb_q.pop_front();
    checks++;
    if (!seen || bus.l2_write !== 1'b1 || bus.l2_addr !== exp.addr || bus.d_stall !== 1'b1 ||
        conflict_cnt !== 16'h1) begin
      errors++;
      $display("FAIL t5_pre: got l2w %b addr %h dstall %b cnt %h want 1 %h 1 1", bus.l2_write,
               bus.l2_addr, bus.d_stall, conflict_cnt, exp.addr);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.l2_write !== 1'b0 || bus.d_stall !== 1'b0 || conflict_cnt !== 16'h0 ||
        bus.l2_addr !== '0 || bus.l2_wdata !== '0) begin
      errors++;
      $display("FAIL t5_async: got l2w %b dstall %b cnt %h addr %h want 0 0 0 0", bus.l2_write,
               bus.d_stall, conflict_cnt, bus.l2_addr);
    end
    bus.l2_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.d_ready !== 1'b0 || bus.i_ready !== 1'b0) begin
      errors++;
      $display("FAIL t5_no_ready: got drdy %b irdy %b want 0 0", bus.d_ready, bus.i_ready);
    end
    bus.l2_ready = 1'b0;
    bus.d_write  = 1'b0;
    reset        = 1'b1;
    bus.i_read   = 1'b1;
    bus.i_addr   = 30'h340;
    sb_q.push_back(mk(1'b0, 1'b0, 30'h340, 128'h0));
    wait_req(cyc, seen);
    exp = sb_q.pop_front();
    checks++;
    if (!seen || cyc != 1 || bus.l2_read !== 1'b1 || bus.l2_addr !== exp.addr) begin
      errors++;
      $display("FAIL t5_after: got cyc %0d l2r %b addr %h want 1 1 %h", cyc, bus.l2_read, bus.l2_addr, exp.addr);
    end
    bus.l2_rdata = 128'h99;
    bus.l2_ready = 1'b1;
    #1;
    checks++;
    if (bus.i_ready !== 1'b1 || bus.i_rdata !== 128'h99) begin
      errors++;
      $display("FAIL t5_after_ready: got irdy %b irdata %h want 1 99", bus.i_ready, bus.i_rdata);
    end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [3:0] prev;
    clear_inputs();
    reset        = 1'b0;
    sbus.i_read  = 1'b1;
    sbus.d_read  = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (s_conflict_cnt !== 4'h1) begin
      errors++;
      $display("FAIL t6_first: got %h want 1", s_conflict_cnt);
    end
    prev = s_conflict_cnt;
    for (int c = 0; c < 66; c++) begin
      @(negedge clk);
      checks++;
      if (s_conflict_cnt < prev) begin
        errors++;
        $display("FAIL t6_wrap: cycle %0d got %h after %h, want no decrease", c, s_conflict_cnt, prev);
      end
      prev = s_conflict_cnt;
    end
    checks++;
    if (s_conflict_cnt !== 4'hF) begin
      errors++;
      $display("FAIL t6_sat: got %h want f", s_conflict_cnt);
    end
    sbus.i_read = 1'b0;
    sbus.d_read = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    clear_inputs();
    sbus.i_read   = 1'b0;
    sbus.i_addr   = 30'h4;
    sbus.d_read   = 1'b0;
    sbus.d_write  = 1'b0;
    sbus.d_addr   = 30'h8;
    sbus.d_wdata  = '0;
    sbus.l2_rdata = '0;
    sbus.l2_ready = 1'b1;

    test_reset();
    test_i_read();
    test_simultaneous();
    test_fairness();
    test_addr_hold();
    test_async_reset();
    test_saturation();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
